// File: rtl/game_sm.sv
// game_sm - local controller for the two-player button-race game.
//
// Conditions the two raw player buttons, runs the IDLE/READY/PLAY/END game
// state machine with its round timer, keeps the local score and registers
// the round result against the peer score delivered by the UART link.
//
// Parameters
//   TICK_DIV          clock cycles per game second (>= 2)
//   GAME_SECONDS      round length in seconds (1..255)
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset; its release is expected
//                     to be synchronous to clk already
//   btn_start         raw start/restart button (asynchronous, active-high)
//   btn_hit           raw scoring button (asynchronous, active-high)
//   start_game        peer-ready level from the UART link (synchronous)
//   score_2nd_player  peer score from the UART link
//   game_state        00 IDLE, 01 READY, 10 PLAY, 11 END
//   my_score          local score, saturating at 255
//   time_left         seconds remaining in the round
//   result            00 none, 01 win, 10 lose, 11 draw
module game_sm #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned GAME_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_hit,
  input  logic       start_game,
  input  logic [7:0] score_2nd_player,
  output logic [1:0] game_state,
  output logic [7:0] my_score,
  output logic [7:0] time_left,
  output logic [1:0] result
);

  localparam int unsigned       TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        SECONDS_INIT = 8'(GAME_SECONDS);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // State codes double as the game_state wire format sent to the peer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READY = 2'b01,
    ST_PLAY  = 2'b10,
    ST_END   = 2'b11
  } state_e;

  // Score increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] score_sat_inc(input logic [7:0] score);
    logic [7:0] next;
    if (score == 8'hFF) begin
      next = 8'hFF;
    end else begin
      next = score + 8'd1;
    end
    return next;
  endfunction

  // Round outcome seen from the local player.
  function automatic logic [1:0] round_result(input logic [7:0] mine,
                                              input logic [7:0] peer);
    logic [1:0] res;
    if (mine > peer) begin
      res = RES_WIN;
    end else if (mine < peer) begin
      res = RES_LOSE;
    end else begin
      res = RES_DRAW;
    end
    return res;
  endfunction

  // [0] metastability flop, [1] synchronised level, [2] previous level.
  logic [2:0] start_sync_q;
  logic [2:0] hit_sync_q;
  logic       start_p_q;
  logic       hit_p_q;

  state_e            state_q,  state_d;
  logic [7:0]        score_q,  score_d;
  logic [7:0]        time_q,   time_d;
  logic [TICK_W-1:0] tick_q,   tick_d;
  logic [1:0]        result_q, result_d;

  // Button synchronisers and registered rising-edge pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_q <= 3'b000;
      hit_sync_q   <= 3'b000;
      start_p_q    <= 1'b0;
      hit_p_q      <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], btn_start};
      hit_sync_q   <= {hit_sync_q[1:0], btn_hit};
      // A held button only pulses once: the level must drop before the next.
      start_p_q    <= start_sync_q[1] & ~start_sync_q[2];
      hit_p_q      <= hit_sync_q[1] & ~hit_sync_q[2];
    end
  end

  // Game state, score, timer and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      score_q  <= 8'd0;
      time_q   <= SECONDS_INIT;
      tick_q   <= '0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      time_q   <= time_d;
      tick_q   <= tick_d;
      result_q <= result_d;
    end
  end

  // Next-state logic including the entry actions of each state.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    time_d   = time_q;
    tick_d   = tick_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        // start_game alone never leaves IDLE; the local player must press.
        if (start_p_q) begin
          state_d = ST_READY;
          score_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READY: begin
        // Peer readiness outranks a simultaneous local cancel.
        if (start_game) begin
          state_d  = ST_PLAY;
          tick_d   = '0;
          time_d   = SECONDS_INIT;
          score_d  = 8'd0;
          result_d = RES_NONE;
        end else if (start_p_q) begin
          state_d  = ST_IDLE;
          time_d   = SECONDS_INIT;
          result_d = RES_NONE;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_PLAY: begin
        // A hit landing on the final tick still counts.
        if (hit_p_q) begin
          score_d = score_sat_inc(score_q);
        end else begin
          score_d = score_q;
        end
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (time_q <= 8'd1) begin
            time_d  = 8'd0;
            state_d = ST_END;
          end else begin
            time_d  = time_q - 8'd1;
            state_d = ST_PLAY;
          end
        end else begin
          tick_d  = tick_q + TICK_W'(1);
          state_d = ST_PLAY;
        end
      end
      ST_END: begin
        // Re-evaluated every cycle so a late peer score is still reflected.
        if (start_p_q) begin
          state_d  = ST_IDLE;
          time_d   = SECONDS_INIT;
          result_d = RES_NONE;
        end else begin
          state_d  = ST_END;
          result_d = round_result(score_q, score_2nd_player);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        time_d   = SECONDS_INIT;
        tick_d   = '0;
        result_d = RES_NONE;
      end
    endcase
  end

  assign game_state = state_q;
  assign my_score   = score_q;
  assign time_left  = time_q;
  assign result     = result_q;

endmodule

// File: tb/tb_game_sm.sv
// tb_game_sm - self-checking bench for game_sm.
//
// Main instance (TICK_DIV=10, GAME_SECONDS=3) is compared every cycle against
// a game-rule model: button pulses come from the sampled raw button history,
// the timer is derived from cycles elapsed in PLAY. A second instance with a
// long round exercises score saturation.
module tb_game_sm;

  localparam int TD  = 10;
  localparam int GS  = 3;
  localparam int TD2 = 400;
  localparam int GS2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_hit, start_game;
  logic [7:0] peer;
  logic [1:0] game_state, result;
  logic [7:0] my_score, time_left;

  logic       b2_start, b2_hit, sg2;
  logic [7:0] peer2;
  logic [1:0] gs2, rs2;
  logic [7:0] sc2, tl2;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int       m_phase;    // 0 idle, 1 ready, 2 play, 3 end
  int       m_score;
  int       m_elapsed;  // clock edges spent in PLAY this round
  int       m_result;
  logic [3:0] bs_hist;  // [3] oldest sampled value, [0] newest
  logic [3:0] bh_hist;

  logic       r_bs, r_bh, r_sg;
  logic [7:0] r_pr;

  game_sm #(.TICK_DIV(TD), .GAME_SECONDS(GS)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_hit(btn_hit),
    .start_game(start_game), .score_2nd_player(peer),
    .game_state(game_state), .my_score(my_score), .time_left(time_left),
    .result(result)
  );

  game_sm #(.TICK_DIV(TD2), .GAME_SECONDS(GS2)) dut_long (
    .clk(clk), .rst(rst), .btn_start(b2_start), .btn_hit(b2_hit),
    .start_game(sg2), .score_2nd_player(peer2),
    .game_state(gs2), .my_score(sc2), .time_left(tl2), .result(rs2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_score   = 0;
    m_elapsed = 0;
    m_result  = 0;
    bs_hist   = 4'b0000;
    bh_hist   = 4'b0000;
  endtask

  function automatic int exp_time();
    if (m_phase == 2) return GS - m_elapsed / TD;
    else if (m_phase == 3) return 0;
    else return GS;
  endfunction

  // One clock edge of the game rules, given the inputs sampled at that edge.
  task automatic model_step(input logic bs, input logic bh, input logic sg,
                            input logic [7:0] pr);
    logic ps, ph;
    // A raw rising edge becomes visible to the game three edges later.
    ps = bs_hist[2] & ~bs_hist[3];
    ph = bh_hist[2] & ~bh_hist[3];
    bs_hist = {bs_hist[2:0], bs};
    bh_hist = {bh_hist[2:0], bh};
    case (m_phase)
      0: if (ps) begin m_phase = 1; m_score = 0; end
      1: begin
        if (sg) begin
          m_phase = 2; m_score = 0; m_elapsed = 0; m_result = 0;
        end else if (ps) begin
          m_phase = 0; m_result = 0;
        end
      end
      2: begin
        if (ph && m_score < 255) m_score++;
        m_elapsed++;
        if (m_elapsed == GS * TD) m_phase = 3;
      end
      default: begin
        if (ps) begin
          m_phase = 0; m_result = 0;
        end else if (m_score > int'(pr)) m_result = 1;
        else if (m_score < int'(pr)) m_result = 2;
        else m_result = 3;
      end
    endcase
  endtask

  // Drive inputs, take one edge, compare every output with the model.
  task automatic cycle(input logic bs, input logic bh, input logic sg,
                       input logic [7:0] pr);
    btn_start  = bs;
    btn_hit    = bh;
    start_game = sg;
    peer       = pr;
    @(posedge clk);
    model_step(bs, bh, sg, pr);
    #1;
    check("state",  game_state, m_phase);
    check("score",  my_score,   m_score);
    check("time",   time_left,  exp_time());
    check("result", result,     m_result);
  endtask

  // A button press: high for hi cycles, then low for lo cycles.
  task automatic press(input logic is_start, input int hi, input int lo,
                       input logic sg, input logic [7:0] pr);
    for (int i = 0; i < hi; i++) cycle(is_start, ~is_start, sg, pr);
    for (int i = 0; i < lo; i++) cycle(1'b0, 1'b0, sg, pr);
  endtask

  task automatic cycle2(input logic bs, input logic bh, input logic sg);
    b2_start = bs;
    b2_hit   = bh;
    sg2      = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  game_state, 0);
    check({tag, "_score"},  my_score,   0);
    check({tag, "_time"},   time_left,  GS);
    check({tag, "_result"}, result,     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    btn_start = 1'b0; btn_hit = 1'b0; start_game = 1'b0; peer = 8'd0;
    b2_start = 1'b0; b2_hit = 1'b0; sg2 = 1'b0; peer2 = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Start press: READY four edges after the raw edge.
    press(1'b1, 2, 3, 1'b0, 8'd0);
    check("t1_ready", game_state, 1);

    // Peer ready -> PLAY; round ends exactly 30 edges later.
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    check("t2_play", game_state, 2);
    check("t2_time3", time_left, 3);
    check("t2_score0", my_score, 0);
    repeat (29) cycle(1'b0, 1'b0, 1'b0, 8'd0);
    check("t2_still_play", game_state, 2);
    check("t2_time1", time_left, 1);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    check("t2_end", game_state, 3);
    check("t2_time0", time_left, 0);

    // Five hits in a round; hits in END and IDLE are ignored.
    press(1'b1, 2, 3, 1'b0, 8'd0);
    check("t3_idle", game_state, 0);
    check("t3_idle_result", result, 0);
    press(1'b1, 2, 3, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    repeat (5) press(1'b0, 3, 3, 1'b0, 8'd0);
    check("t3_end", game_state, 3);
    check("t3_score5", my_score, 5);
    press(1'b0, 2, 4, 1'b0, 8'd0);
    check("t3_end_hit", my_score, 5);
    press(1'b1, 2, 3, 1'b0, 8'd0);
    press(1'b0, 2, 4, 1'b0, 8'd0);
    check("t3_idle_hit", my_score, 5);
    check("t3_idle2", game_state, 0);

    // Result tracks the peer score while in END.
    press(1'b1, 2, 3, 1'b0, 8'd0);
    check("t5_ready_clear", my_score, 0);
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    repeat (7) press(1'b0, 1, 1, 1'b0, 8'd0);
    for (int i = 0; i < 40 && game_state != 2'b11; i++) cycle(1'b0, 1'b0, 1'b0, 8'd5);
    check("t5_end", game_state, 3);
    check("t5_score7", my_score, 7);
    cycle(1'b0, 1'b0, 1'b0, 8'd5);
    check("t5_win", result, 1);
    cycle(1'b0, 1'b0, 1'b0, 8'd9);
    check("t5_lose", result, 2);
    cycle(1'b0, 1'b0, 1'b0, 8'd7);
    check("t5_draw", result, 3);
    press(1'b1, 2, 3, 1'b0, 8'd7);
    check("t5_idle", game_state, 0);
    check("t5_idle_result", result, 0);
    check("t5_idle_time", time_left, 3);

    // Asynchronous reset in the middle of a round.
    press(1'b1, 2, 3, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd0);
    repeat (4) press(1'b0, 1, 1, 1'b0, 8'd0);
    for (int i = 0; i < 30 && time_left != 8'd2; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0);
    check("t6_time2", time_left, 2);
    check("t6_score4", my_score, 4);
    rst = 1'b0;
    #1;
    check_reset_values("t6_async");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("t6_held");
    rst = 1'b1;
    press(1'b1, 2, 3, 1'b0, 8'd0);
    repeat (50) cycle(1'b0, 1'b0, 1'b0, 8'd0);
    check("t6_ready_stays", game_state, 1);

    // Randomised play against the model.
    r_bs = 1'b0; r_bh = 1'b0; r_sg = 1'b0; r_pr = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)  r_bh = ~r_bh;
      if ($urandom_range(0, 15) == 0) r_bs = ~r_bs;
      if ($urandom_range(0, 9) == 0)  r_sg = ~r_sg;
      if ($urandom_range(0, 7) == 0)  r_pr = 8'($urandom_range(0, 12));
      cycle(r_bs, r_bh, r_sg, r_pr);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'd0);

    // Long round on the second instance: 260 hits saturate at 255.
    cycle2(1'b1, 1'b0, 1'b0);
    cycle2(1'b1, 1'b0, 1'b0);
    repeat (3) cycle2(1'b0, 1'b0, 1'b0);
    check("sat_ready", gs2, 1);
    cycle2(1'b0, 1'b0, 1'b1);
    check("sat_play", gs2, 2);
    repeat (250) begin
      cycle2(1'b0, 1'b1, 1'b0);
      cycle2(1'b0, 1'b0, 1'b0);
    end
    repeat (4) cycle2(1'b0, 1'b0, 1'b0);
    check("sat_250", sc2, 250);
    repeat (10) begin
      cycle2(1'b0, 1'b1, 1'b0);
      cycle2(1'b0, 1'b0, 1'b0);
    end
    repeat (4) cycle2(1'b0, 1'b0, 1'b0);
    check("sat_255", sc2, 255);
    check("sat_still_play", gs2, 2);
    for (int i = 0; i < 400 && gs2 != 2'b11; i++) cycle2(1'b0, 1'b0, 1'b0);
    check("sat_end", gs2, 3);
    check("sat_end_time", tl2, 0);
    check("sat_end_score", sc2, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
